// File: rtl/audio_system_pio_keys_if.sv
// audio_system_pio_keys_if: Avalon-MM slave bus bundle for the pushbutton PIO.
interface audio_system_pio_keys_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/audio_system_pio_keys.sv
// audio_system_pio_keys: debounced pushbutton input PIO with sticky edge capture and masked irq.
module audio_system_pio_keys #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int IDLE_LEVEL      = 1,
   parameter int EDGE_TYPE       = 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   audio_system_pio_keys_if.slave bus,
   input  logic [WIDTH-1:0]       in_port,
   output logic                   irq
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WIDTH-1:0] IDLE = {WIDTH{IDLE_LEVEL != 0}};
   logic [WIDTH-1:0] sync1, sync2, stable, accept, evt, mask, edgecapture, clr;
   logic [CW-1:0]    cnt [WIDTH];
   logic [31:0]      rd;
   logic             wr;
   always_comb begin
      wr = bus.chipselect && !bus.write_n;
      clr = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
      for (int i = 0; i < WIDTH; i++) accept[i] = sync2[i] != stable[i] && cnt[i] == LAST;
      // accept & sync2 is the new level, so it picks out rising flips
      evt = EDGE_TYPE == 0 ? accept & sync2 : EDGE_TYPE == 1 ? accept & ~sync2 : accept;
      rd = bus.address == 2'd0 ? 32'(stable) :
           bus.address == 2'd2 ? 32'(mask) :
           bus.address == 2'd3 ? 32'(edgecapture) : '0;
   end
   assign irq = |(edgecapture & mask);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1        <= IDLE;
         sync2        <= IDLE;
         stable       <= IDLE;
         mask         <= '0;
         edgecapture  <= '0;
         bus.readdata <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         sync1  <= in_port;
         sync2  <= sync1;
         stable <= stable ^ accept;
         for (int i = 0; i < WIDTH; i++)
            cnt[i] <= (sync2[i] == stable[i] || accept[i]) ? '0 : cnt[i] + CW'(1);
         if (wr && bus.address == 2'd2) mask <= bus.writedata[WIDTH-1:0];
         // a new event wins over a same-cycle clear
         edgecapture  <= (edgecapture & ~clr) | evt;
         bus.readdata <= rd;
      end
   end
endmodule

// File: tb/tb_audio_system_pio_keys.sv
// tb_audio_system_pio_keys: directed and random checks against a sliding-window debounce model.
module tb_audio_system_pio_keys;
   localparam int D = 4;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic [3:0] in_port = 4'hF;
   logic irq;
   int vectors = 0, errors = 0;
   audio_system_pio_keys_if bus();
   audio_system_pio_keys #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .IDLE_LEVEL(1), .EDGE_TYPE(1)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .in_port(in_port), .irq(irq));
   always #5 clk = ~clk;

   // model: a level is accepted once the last D synchronized samples all oppose it
   logic [3:0]  pipe[$], hist[$];
   logic [3:0]  s2, m_stable, m_ec, m_mask, flip, m_clr;
   logic [31:0] m_rd;
   logic        all_diff;
   wire         m_irq = |(m_ec & m_mask);
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe = '{4'hF, 4'hF};
         hist.delete();
         m_stable = 4'hF; m_ec = 0; m_mask = 0; m_rd = 0;
      end else begin
         case (bus.address)
            2'd0: m_rd = {28'b0, m_stable};
            2'd2: m_rd = {28'b0, m_mask};
            2'd3: m_rd = {28'b0, m_ec};
            default: m_rd = 0;
         endcase
         pipe.push_back(in_port);
         s2 = pipe.pop_front();
         hist.push_back(s2);
         if (hist.size() > D) void'(hist.pop_front());
         flip = 0;
         if (hist.size() == D)
            for (int b = 0; b < 4; b++) begin
               all_diff = 1;
               foreach (hist[j]) if (hist[j][b] == m_stable[b]) all_diff = 0;
               flip[b] = all_diff;
            end
         m_clr = (bus.chipselect && !bus.write_n && bus.address == 2'd3) ? bus.writedata[3:0] : 4'h0;
         if (bus.chipselect && !bus.write_n && bus.address == 2'd2) m_mask = bus.writedata[3:0];
         m_ec = (m_ec & ~m_clr) | (flip & m_stable);
         m_stable = m_stable ^ flip;
      end
   end

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.address = a; bus.writedata = d; bus.chipselect = 1; bus.write_n = 0;
      @(negedge clk);
      bus.chipselect = 0; bus.write_n = 1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      bus.address = a; bus.chipselect = 1; bus.write_n = 1;
      @(negedge clk);
      d = bus.readdata;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      bus.address = 1; bus.chipselect = 0; bus.write_n = 1; bus.writedata = 0;
      in_port = 4'hF;
      #2 reset_n = 0;
      #1;
      vectors++; if (bus.readdata !== 0) begin errors++; $display("FAIL reset_rd: got %h want 0", bus.readdata); end
      vectors++; if (irq !== 0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
      repeat (3) @(negedge clk);
      reset_n = 1;
      repeat (20) @(negedge clk);
      vectors++; if (bus.readdata !== 0) begin errors++; $display("FAIL idle_rd: got %h want 0", bus.readdata); end
      vectors++; if (irq !== 0) begin errors++; $display("FAIL idle_irq: got %b want 0", irq); end
      rd(0, d);
      vectors++; if (d !== 32'hF) begin errors++; $display("FAIL idle_data: got %h want f", d); end
      rd(3, d);
      vectors++; if (d !== 0) begin errors++; $display("FAIL idle_ec: got %h want 0", d); end
   endtask

   task automatic test_press;
      logic [31:0] d;
      wr(2, 32'h1);
      in_port = 4'hE;
      repeat (5) @(negedge clk);
      vectors++; if (irq !== 0) begin errors++; $display("FAIL press_early_irq: got %b want 0", irq); end
      @(negedge clk);
      vectors++; if (irq !== 1) begin errors++; $display("FAIL press_irq: got %b want 1", irq); end
      vectors++; if (m_irq !== 1) begin errors++; $display("FAIL press_model_irq: got %b want 1", m_irq); end
      rd(0, d);
      vectors++; if (d !== 32'hE) begin errors++; $display("FAIL press_data: got %h want e", d); end
      rd(3, d);
      vectors++; if (d !== 32'h1) begin errors++; $display("FAIL press_ec: got %h want 1", d); end
   endtask

   task automatic test_glitch;
      logic [31:0] d;
      in_port = 4'hC;
      repeat (3) @(negedge clk);
      in_port = 4'hE;
      repeat (10) @(negedge clk);
      rd(3, d);
      vectors++; if (d !== 32'h1) begin errors++; $display("FAIL glitch_ec: got %h want 1", d); end
      rd(0, d);
      vectors++; if (d !== 32'hE) begin errors++; $display("FAIL glitch_data: got %h want e", d); end
      vectors++; if (irq !== 1) begin errors++; $display("FAIL glitch_irq: got %b want 1", irq); end
      in_port = 4'hC;
      repeat (8) @(negedge clk);
      rd(3, d);
      vectors++; if (d !== 32'h3) begin errors++; $display("FAIL hold_ec: got %h want 3", d); end
      vectors++; if (irq !== 1) begin errors++; $display("FAIL hold_irq: got %b want 1", irq); end
   endtask

   task automatic test_w1c;
      logic [31:0] d;
      wr(3, 32'h1);
      vectors++; if (irq !== 0) begin errors++; $display("FAIL w1c_irq: got %b want 0", irq); end
      rd(3, d);
      vectors++; if (d !== 32'h2) begin errors++; $display("FAIL w1c_ec: got %h want 2", d); end
   endtask

   task automatic test_release;
      logic [31:0] d;
      bus.address = 0; bus.chipselect = 0;
      in_port = 4'hD;
      repeat (6) @(negedge clk);
      vectors++; if (bus.readdata !== 32'hC) begin errors++; $display("FAIL rel_early: got %h want c", bus.readdata); end
      @(negedge clk);
      vectors++; if (bus.readdata !== 32'hD) begin errors++; $display("FAIL rel_data: got %h want d", bus.readdata); end
      rd(3, d);
      vectors++; if (d !== 32'h2) begin errors++; $display("FAIL rel_ec: got %h want 2", d); end
      vectors++; if (irq !== 0) begin errors++; $display("FAIL rel_irq: got %b want 0", irq); end
   endtask

   task automatic test_collision;
      logic [31:0] d;
      in_port = 4'hC;
      repeat (5) @(negedge clk);
      wr(3, 32'h1);
      vectors++; if (irq !== 1) begin errors++; $display("FAIL coll_irq: got %b want 1", irq); end
      rd(3, d);
      vectors++; if (d !== 32'h3) begin errors++; $display("FAIL coll_ec: got %h want 3", d); end
   endtask

   task automatic test_random;
      int hold = 0;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         vectors++; if (bus.readdata !== m_rd) begin errors++; $display("FAIL rand_rd: got %h want %h at %0d", bus.readdata, m_rd, n); end
         vectors++; if (irq !== m_irq) begin errors++; $display("FAIL rand_irq: got %b want %b at %0d", irq, m_irq, n); end
         if (hold == 0) begin in_port = 4'($urandom); hold = $urandom_range(1, 9); end
         else hold--;
         bus.address = 2'($urandom);
         bus.chipselect = 1'($urandom);
         bus.write_n = $urandom_range(0, 7) != 0;
         bus.writedata = $urandom;
      end
      bus.chipselect = 0; bus.write_n = 1;
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      wr(2, 32'hF);
      in_port = 4'hF;
      repeat (12) @(negedge clk);
      in_port = 4'h0;
      repeat (12) @(negedge clk);
      bus.address = 3;
      @(negedge clk);
      vectors++; if (bus.readdata !== 32'hF) begin errors++; $display("FAIL mid_pre_ec: got %h want f", bus.readdata); end
      vectors++; if (irq !== 1) begin errors++; $display("FAIL mid_pre_irq: got %b want 1", irq); end
      in_port = 4'hF;
      repeat (4) @(negedge clk);
      #1 reset_n = 0;
      #1;
      vectors++; if (bus.readdata !== 0) begin errors++; $display("FAIL mid_rd: got %h want 0", bus.readdata); end
      vectors++; if (irq !== 0) begin errors++; $display("FAIL mid_irq: got %b want 0", irq); end
      @(negedge clk);
      reset_n = 1;
      repeat (20) @(negedge clk);
      vectors++; if (irq !== 0) begin errors++; $display("FAIL post_irq: got %b want 0", irq); end
      rd(3, d);
      vectors++; if (d !== 0) begin errors++; $display("FAIL post_ec: got %h want 0", d); end
      rd(0, d);
      vectors++; if (d !== 32'hF) begin errors++; $display("FAIL post_data: got %h want f", d); end
   endtask

   initial begin
      test_reset;
      test_press;
      test_glitch;
      test_w1c;
      test_release;
      test_collision;
      test_random;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
